// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters.
// Owner codes, FSM encoding and AXI burst length width.
package axi_ic_pkg;

    localparam int LEN_W = 8;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_M1   = 2'b01;
    localparam logic [1:0] SEL_M2   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } ar_state_e;

endpackage

// File: rtl/rd_slave_arbiter_if.sv
// Read-path signals between two masters, one slave and its arbiter.
// The arbiter sits on the slave modport.
interface rd_slave_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              m1_ARVALID;
    logic              m2_ARVALID;
    logic [ADDR_W-1:0] m1_ARADDR;
    logic [ADDR_W-1:0] m2_ARADDR;
    logic [7:0]        m1_ARLEN;
    logic [7:0]        m2_ARLEN;
    logic              m1_RREADY;
    logic              m2_RREADY;
    logic              s_ARREADY;
    logic              s_RVALID;
    logic              s_RLAST;
    logic [1:0]        mas_sel;
    logic              busy;
    logic              len_err;
    logic              timeout_err;

    modport master (
        output m1_ARVALID, m2_ARVALID,
        output m1_ARADDR, m2_ARADDR,
        output m1_ARLEN, m2_ARLEN,
        output m1_RREADY, m2_RREADY,
        output s_ARREADY, s_RVALID, s_RLAST,
        input  mas_sel, busy,
        input  len_err, timeout_err
    );

    modport slave (
        input  m1_ARVALID, m2_ARVALID,
        input  m1_ARADDR, m2_ARADDR,
        input  m1_ARLEN, m2_ARLEN,
        input  m1_RREADY, m2_RREADY,
        input  s_ARREADY, s_RVALID, s_RLAST,
        output mas_sel, busy,
        output len_err, timeout_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves only
// when the owner reports an accepted transfer via adv_i.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    input  logic [1:0] served_i,
    output logic [1:0] gnt_o
);

    // ptr_q set: requester 2 wins a tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = served_i[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rd_slave_arbiter.sv
// Per-slave AR arbiter: grants one master, holds ownership
// through the final R beat, checks beat count and stalls.
module rd_slave_arbiter
    import axi_ic_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
    parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'hF000_0000),
    parameter int                TIMEOUT   = 256
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    rd_slave_arbiter_if.slave bus
);

    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    function automatic logic hit(input logic [ADDR_W-1:0] a);
        return (a & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);
    endfunction

    ar_state_e        state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             len_err_q, len_err_d;
    logic             to_q, to_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       own_arvalid;
    logic       own_rready;
    logic       ar_hs;
    logic       r_beat;
    logic       wd_hit;

    assign req[0] = bus.m1_ARVALID & hit(bus.m1_ARADDR);
    assign req[1] = bus.m2_ARVALID & hit(bus.m2_ARADDR);

    assign own_arvalid = (sel_q == SEL_M1 && bus.m1_ARVALID)
                       | (sel_q == SEL_M2 && bus.m2_ARVALID);
    assign own_rready  = (sel_q == SEL_M1 && bus.m1_RREADY)
                       | (sel_q == SEL_M2 && bus.m2_RREADY);

    assign ar_hs  = (state_q == ST_ADDR) & bus.s_ARREADY & own_arvalid;
    assign r_beat = bus.s_RVALID & own_rready;
    assign wd_hit = (TIMEOUT != 0) && (wd_q == WD_W'(WD_LIM));

    rr_arb2 u_arb (
        .clk_i    (ACLK),
        .rst_ni   (ARESETn),
        .req_i    (req),
        .adv_i    (ar_hs),
        .served_i (sel_q),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        len_d     = len_q;
        beat_d    = beat_q;
        wd_d      = wd_q + WD_W'(1);
        len_err_d = 1'b0;
        to_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (|gnt) begin
                    sel_d   = gnt;
                    len_d   = gnt[1] ? bus.m2_ARLEN : bus.m1_ARLEN;
                    beat_d  = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    wd_d    = '0;
                    state_d = ST_DATA;
                end else if (wd_hit) begin
                    wd_d    = '0;
                    to_d    = 1'b1;
                    sel_d   = SEL_IDLE;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (r_beat) begin
                    wd_d = '0;
                    if (bus.s_RLAST) begin
                        len_err_d = (beat_q != len_q);
                        sel_d     = SEL_IDLE;
                        state_d   = ST_IDLE;
                    end else begin
                        // too many beats: length already reached
                        len_err_d = (beat_q == len_q);
                        beat_d    = beat_q + LEN_W'(1);
                    end
                end else if (wd_hit) begin
                    wd_d    = '0;
                    to_d    = 1'b1;
                    sel_d   = SEL_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sel_d   = SEL_IDLE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_IDLE;
            len_q     <= '0;
            beat_q    <= '0;
            wd_q      <= '0;
            len_err_q <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            wd_q      <= wd_d;
            len_err_q <= len_err_d;
            to_q      <= to_d;
        end
    end

    assign bus.mas_sel     = sel_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.len_err     = len_err_q;
    assign bus.timeout_err = to_q;

endmodule

// File: tb/tb_rd_slave_arbiter.sv
// Bench for rd_slave_arbiter: directed scenarios with literal
// expectations plus random traffic against a transaction model.
module tb_rd_slave_arbiter;

    localparam int AW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rd_slave_arbiter_if #(.ADDR_W(AW)) bus ();

    rd_slave_arbiter #(
        .ADDR_W    (AW),
        .ADDR_BASE (32'h0000_0000),
        .ADDR_MASK (32'hF000_0000),
        .TIMEOUT   (TO)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction model: who owns the slave, whether its address
    // was taken, how many beats came back, idle cycles since progress.
    int   m_owner, m_prefer, m_len, m_beats, m_stall;
    bit   m_acc, r1, r2, own_av, own_rr;
    logic [1:0] e_sel;
    logic e_busy, e_lerr, e_terr;

    function automatic bit inreg(input logic [31:0] a);
        return a[31:28] == 4'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_prefer = 1; m_len = 0;
            m_beats = 0; m_stall = 0; m_acc = 0;
            e_lerr = 0; e_terr = 0;
        end else begin
            e_lerr = 0;
            e_terr = 0;
            r1 = bus.m1_ARVALID && inreg(bus.m1_ARADDR);
            r2 = bus.m2_ARVALID && inreg(bus.m2_ARADDR);
            own_av = (m_owner == 1) ? bus.m1_ARVALID : bus.m2_ARVALID;
            own_rr = (m_owner == 1) ? bus.m1_RREADY : bus.m2_RREADY;
            if (m_owner == 0) begin
                if (r1 && r2) m_owner = m_prefer;
                else if (r1) m_owner = 1;
                else if (r2) m_owner = 2;
                if (m_owner != 0) begin
                    m_len = (m_owner == 1) ? int'(bus.m1_ARLEN)
                                           : int'(bus.m2_ARLEN);
                    m_beats = 0; m_stall = 0; m_acc = 0;
                end
            end else begin
                m_stall++;
                if (!m_acc && bus.s_ARREADY && own_av) begin
                    m_acc = 1;
                    m_prefer = 3 - m_owner;
                    m_stall = 0;
                end else if (m_acc && bus.s_RVALID && own_rr) begin
                    m_beats++;
                    m_stall = 0;
                    if (bus.s_RLAST) begin
                        e_lerr = (m_beats != m_len + 1);
                        m_owner = 0;
                    end else begin
                        e_lerr = (m_beats == m_len + 1);
                    end
                end else if (m_stall == TO) begin
                    e_terr = 1;
                    m_owner = 0;
                end
            end
        end
        e_sel  = 2'(m_owner);
        e_busy = (m_owner != 0);
    end

    always @(negedge clk) begin
        chk("mas_sel", {30'd0, bus.mas_sel}, {30'd0, e_sel});
        chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
        chk("len_err", {31'd0, bus.len_err}, {31'd0, e_lerr});
        chk("timeout_err", {31'd0, bus.timeout_err}, {31'd0, e_terr});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m1_ARVALID = 0; bus.m2_ARVALID = 0;
        bus.m1_ARADDR = '0; bus.m2_ARADDR = '0;
        bus.m1_ARLEN = '0;  bus.m2_ARLEN = '0;
        bus.m1_RREADY = 0;  bus.m2_RREADY = 0;
        bus.s_ARREADY = 0;  bus.s_RVALID = 0; bus.s_RLAST = 0;
    endtask

    task automatic set_req(input int m, input logic [31:0] a,
                           input logic [7:0] l);
        if (m == 1) begin
            bus.m1_ARVALID = 1; bus.m1_ARADDR = a; bus.m1_ARLEN = l;
        end else begin
            bus.m2_ARVALID = 1; bus.m2_ARADDR = a; bus.m2_ARLEN = l;
        end
    endtask

    task automatic clr_req(input int m);
        if (m == 1) bus.m1_ARVALID = 0;
        else bus.m2_ARVALID = 0;
    endtask

    // Address handshake, then n beats with RLAST on the last.
    task automatic finish_burst(input int m, input int n);
        bus.s_ARREADY = 1;
        step();
        bus.s_ARREADY = 0;
        clr_req(m);
        chk("hold_sel", {30'd0, bus.mas_sel}, 32'(m));
        for (int i = 0; i < n; i++) begin
            bus.s_RVALID = 1;
            bus.s_RLAST = (i == n - 1);
            if (m == 1) bus.m1_RREADY = 1;
            else bus.m2_RREADY = 1;
            step();
        end
        bus.s_RVALID = 0; bus.s_RLAST = 0;
        bus.m1_RREADY = 0; bus.m2_RREADY = 0;
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", {30'd0, bus.mas_sel}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_lerr", {31'd0, bus.len_err}, 32'd0);
        chk("rst_terr", {31'd0, bus.timeout_err}, 32'd0);
        rst_n = 1;
        step();

        // simultaneous requests twice: m1 then m2
        set_req(1, 32'h20, 8'd0);
        set_req(2, 32'h24, 8'd0);
        step();
        chk("rr1_sel", {30'd0, bus.mas_sel}, 32'h1);
        finish_burst(1, 1);
        chk("rr_gap_busy", {31'd0, bus.busy}, 32'd0);
        set_req(1, 32'h28, 8'd0);
        step();
        chk("rr2_sel", {30'd0, bus.mas_sel}, 32'h2);
        chk("rr2_busy", {31'd0, bus.busy}, 32'd1);
        clr_req(1);
        finish_burst(2, 1);
        step();

        // single m1 burst of four beats
        set_req(1, 32'h0000_0010, 8'd3);
        chk("lat_sel", {30'd0, bus.mas_sel}, 32'd0);
        step();
        chk("m1_sel", {30'd0, bus.mas_sel}, 32'h1);
        finish_burst(1, 4);
        chk("m1_end_sel", {30'd0, bus.mas_sel}, 32'd0);
        chk("m1_end_lerr", {31'd0, bus.len_err}, 32'd0);
        step();

        // decode miss
        set_req(2, 32'h1000_0000, 8'd0);
        repeat (3) step();
        chk("miss_sel", {30'd0, bus.mas_sel}, 32'd0);
        chk("miss_busy", {31'd0, bus.busy}, 32'd0);
        clr_req(2);
        step();

        // short burst: RLAST on beat 2 of 4
        set_req(2, 32'h40, 8'd3);
        step();
        chk("short_sel", {30'd0, bus.mas_sel}, 32'h2);
        finish_burst(2, 2);
        chk("short_lerr", {31'd0, bus.len_err}, 32'd1);
        chk("short_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("short_lerr_off", {31'd0, bus.len_err}, 32'd0);

        // watchdog in ADDR; pointer favours m1 here
        set_req(1, 32'h50, 8'd1);
        set_req(2, 32'h60, 8'd1);
        step();
        chk("to_sel", {30'd0, bus.mas_sel}, 32'h1);
        repeat (TO - 1) step();
        chk("to_busy_pre", {31'd0, bus.busy}, 32'd1);
        chk("to_terr_pre", {31'd0, bus.timeout_err}, 32'd0);
        step();
        chk("to_terr", {31'd0, bus.timeout_err}, 32'd1);
        chk("to_sel_idle", {30'd0, bus.mas_sel}, 32'd0);
        step();
        chk("to_regrant", {30'd0, bus.mas_sel}, 32'h1);
        clr_req(2);
        finish_burst(1, 2);
        step();

        // async reset during beat 2 of an eight-beat burst
        set_req(1, 32'h70, 8'd7);
        step();
        bus.s_ARREADY = 1;
        step();
        bus.s_ARREADY = 0;
        clr_req(1);
        bus.s_RVALID = 1; bus.m1_RREADY = 1;
        step();
        #2;
        rst_n = 0;
        #1;
        chk("arst_sel", {30'd0, bus.mas_sel}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        step();
        set_req(2, 32'h80, 8'd0);
        step();
        chk("post_rst_sel", {30'd0, bus.mas_sel}, 32'h2);
        clr_req(2);
        finish_burst(2, 1);
        step();

        // random traffic, with periodic quiet windows to force timeouts
        for (int i = 0; i < 3000; i++) begin
            bit quiet;
            quiet = (i % 400) < 20;
            bus.m1_ARVALID = $urandom_range(0, 2) != 0;
            bus.m2_ARVALID = $urandom_range(0, 2) != 0;
            bus.m1_ARADDR = ($urandom_range(0, 7) != 0) ? 32'(i * 4)
                                                        : 32'h2000_0000;
            bus.m2_ARADDR = ($urandom_range(0, 7) != 0) ? 32'h0100_0000
                                                        : 32'hF000_0040;
            bus.m1_ARLEN = 8'($urandom_range(0, 3));
            bus.m2_ARLEN = 8'($urandom_range(0, 3));
            bus.m1_RREADY = $urandom_range(0, 3) != 0;
            bus.m2_RREADY = $urandom_range(0, 3) != 0;
            bus.s_ARREADY = !quiet && ($urandom_range(0, 3) == 0);
            bus.s_RVALID = !quiet && ($urandom_range(0, 1) == 0);
            bus.s_RLAST = $urandom_range(0, 3) == 0;
            step();
        end

        idle_inputs();
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
